// File: rtl/reaction_timer.sv
// Reaction-game round controller: arms the delay counter, times the punch in ms ticks, flags fouls/timeouts.
// Optional `define BEST_TIME_EN adds a best_ms output tracking the fastest legal reaction since reset.
module reaction_timer #(
    parameter int TICK_DIV = 50000,
    parameter int TIME_W   = 16,
    parameter int MAX_TIME = 9999
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              go_n,
    input  logic              punch,
    output logic              delay_rst_n,
    output logic              busy,
    output logic [TIME_W-1:0] react_ms,
    output logic              result_valid,
    output logic              foul,
    output logic              timeout
`ifdef BEST_TIME_EN
    ,
    output logic [TIME_W-1:0] best_ms
`endif
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ARM  = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]     PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [TIME_W-1:0] TIME_MAX   = TIME_W'(MAX_TIME);
    localparam logic [TIME_W-1:0] TIME_PRE   = TIME_W'(MAX_TIME - 1);

    logic [1:0]    state;
    logic [PW-1:0] presc;
    logic          s1, s2, s2_d;
    logic          punch_edge;
    logic          legal_finish;

    assign punch_edge = s2 & ~s2_d;
    // A legal punch ends the round at this edge with react_ms frozen at its current value.
    assign legal_finish = punch_edge && ((state == ARM && !go_n) || state == RUN);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            presc        <= '0;
            s1           <= 1'b0;
            s2           <= 1'b0;
            s2_d         <= 1'b0;
            delay_rst_n  <= 1'b0;
            busy         <= 1'b0;
            react_ms     <= '0;
            result_valid <= 1'b0;
            foul         <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            s1   <= punch;
            s2   <= s1;
            s2_d <= s2;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state        <= ARM;
                        react_ms     <= '0;
                        result_valid <= 1'b0;
                        foul         <= 1'b0;
                        timeout      <= 1'b0;
                        delay_rst_n  <= 1'b1;
                        busy         <= 1'b1;
                    end
                end
                ARM: begin
                    if (!go_n) begin
                        presc <= '0;
                        if (punch_edge) begin
                            state        <= DONE;
                            result_valid <= 1'b1;
                            delay_rst_n  <= 1'b0;
                            busy         <= 1'b0;
                        end else begin
                            state <= RUN;
                        end
                    end else if (punch_edge) begin
                        state       <= DONE;
                        foul        <= 1'b1;
                        delay_rst_n <= 1'b0;
                        busy        <= 1'b0;
                    end
                end
                RUN: begin
                    // Punch has priority over a coincident tick, so no increment on that edge.
                    if (punch_edge) begin
                        state        <= DONE;
                        result_valid <= 1'b1;
                        delay_rst_n  <= 1'b0;
                        busy         <= 1'b0;
                    end else if (presc == PRESC_LAST) begin
                        presc <= '0;
                        if (react_ms == TIME_PRE) begin
                            react_ms    <= TIME_MAX;
                            timeout     <= 1'b1;
                            state       <= DONE;
                            delay_rst_n <= 1'b0;
                            busy        <= 1'b0;
                        end else begin
                            react_ms <= react_ms + TIME_W'(1);
                        end
                    end else begin
                        presc <= presc + PW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BEST_TIME_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            best_ms <= '1;
        end else if (legal_finish && react_ms < best_ms) begin
            best_ms <= react_ms;
        end
    end
`endif

endmodule

// File: tb/tb_reaction_timer.sv
// Self-checking bench for reaction_timer (TICK_DIV=4, MAX_TIME=20); round results go through a scoreboard queue.
// Define BEST_TIME_EN to also exercise the best_ms output.
module tb_reaction_timer;

    localparam int TICK_DIV = 4;
    localparam int TIME_W   = 16;
    localparam int MAX_TIME = 20;
    localparam int W        = TIME_W + 3;
    localparam logic [1:0] ST_IDLE = 2'd0;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic go_n = 1'b1;
    logic punch = 1'b0;
    logic delay_rst_n, busy, result_valid, foul, timeout;
    logic [TIME_W-1:0] react_ms;
`ifdef BEST_TIME_EN
    logic [TIME_W-1:0] best_ms;
`endif

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    reaction_timer #(.TICK_DIV(TICK_DIV), .TIME_W(TIME_W), .MAX_TIME(MAX_TIME)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .go_n(go_n),
        .punch(punch),
        .delay_rst_n(delay_rst_n),
        .busy(busy),
        .react_ms(react_ms),
        .result_valid(result_valid),
        .foul(foul),
        .timeout(timeout)
`ifdef BEST_TIME_EN
        ,
        .best_ms(best_ms)
`endif
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    // Plays one legal round whose punch is registered at edge e after RUN entry (e >= 3).
    task automatic play_round(input int e, input bit do_start, input string name);
        logic [W-1:0] exp;
        logic [W-1:0] got;
        if (do_start) pulse_start();
        step($urandom_range(0, 5));
        go_n = 1'b0;
        exp_q.push_back({TIME_W'((e - 1) / TICK_DIV), 1'b1, 1'b0, 1'b0});
        step(1);
        step(e - 3);
        punch = 1'b1;
        step(3);
        got = {react_ms, result_valid, foul, timeout};
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, got %h", name, got);
        end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
                errors++;
                $display("FAIL %s: got react/valid/foul/to %h required %h", name, got, exp);
            end
        end
        checks++;
        if ({busy, delay_rst_n} !== 2'b00) begin
            errors++;
            $display("FAIL %s_done: busy/delay_rst_n %b required 00", name, {busy, delay_rst_n});
        end
        punch = 1'b0;
        go_n  = 1'b1;
        step(3);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start = 1'($urandom_range(0, 1));
            go_n  = 1'($urandom_range(0, 1));
            punch = 1'($urandom_range(0, 1));
            step(1);
        end
        checks++;
        if ({delay_rst_n, busy, result_valid, foul, timeout} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b required 00000", {delay_rst_n, busy, result_valid, foul, timeout});
        end
        checks++;
        if (react_ms !== '0) begin
            errors++;
            $display("FAIL reset_react: got %0d required 0", react_ms);
        end
        checks++;
        if (dut.state !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_state: got %0d required %0d", dut.state, ST_IDLE);
        end
`ifdef BEST_TIME_EN
        checks++;
        if (best_ms !== '1) begin
            errors++;
            $display("FAIL reset_best: got %h required ffff", best_ms);
        end
`endif
        start = 1'b0;
        go_n  = 1'b1;
        punch = 1'b0;
        rst   = 1'b1;
        step(3);
        checks++;
        if ({delay_rst_n, busy} !== 2'b00 || dut.state !== ST_IDLE) begin
            errors++;
            $display("FAIL idle_after_reset: delay_rst_n/busy %b state %0d required 00 / 0", {delay_rst_n, busy}, dut.state);
        end
    endtask

    task automatic test_normal();
        pulse_start();
        checks++;
        if ({delay_rst_n, busy} !== 2'b11) begin
            errors++;
            $display("FAIL arm_outputs: delay_rst_n/busy %b required 11", {delay_rst_n, busy});
        end
        play_round(30, 1'b0, "normal_30");
    endtask

    task automatic test_foul();
        logic [W-1:0] exp;
        logic [W-1:0] got;
        pulse_start();
        step(2);
        punch = 1'b1;
        exp_q.push_back({TIME_W'(0), 1'b0, 1'b1, 1'b0});
        step(3);
        got = {react_ms, result_valid, foul, timeout};
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL foul: got %h required %h", got, exp);
        end
        // a fresh punch in DONE must not disturb the held result
        punch = 1'b0;
        step(3);
        punch = 1'b1;
        step(4);
        checks++;
        if ({react_ms, result_valid, foul, timeout, busy} !== {TIME_W'(0), 4'b0100}) begin
            errors++;
            $display("FAIL foul_hold: got %h required %h", {react_ms, result_valid, foul, timeout, busy}, {TIME_W'(0), 4'b0100});
        end
        punch = 1'b0;
        step(3);
        pulse_start();
        checks++;
        if ({foul, busy, delay_rst_n} !== 3'b011) begin
            errors++;
            $display("FAIL rearm_clears_foul: foul/busy/delay_rst_n %b required 011", {foul, busy, delay_rst_n});
        end
        play_round(13, 1'b0, "after_foul_13");
    endtask

    task automatic test_timeout();
        logic [W-1:0] exp;
        logic [W-1:0] got;
        pulse_start();
        go_n = 1'b0;
        exp_q.push_back({TIME_W'(MAX_TIME), 1'b0, 1'b0, 1'b1});
        step(1);
        for (int k = 1; k <= MAX_TIME; k++) begin
            step(TICK_DIV);
            checks++;
            if (react_ms !== TIME_W'(k) || timeout !== (k == MAX_TIME)) begin
                errors++;
                $display("FAIL timeout_step%0d: react %0d timeout %b required %0d %b", k, react_ms, timeout, k, (k == MAX_TIME));
            end
        end
        step(2 * TICK_DIV);
        got = {react_ms, result_valid, foul, timeout};
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_final: got %h busy %b required %h busy 0", got, busy, exp);
        end
        go_n = 1'b1;
        step(2);
    endtask

    task automatic test_mid_reset();
        pulse_start();
        go_n = 1'b0;
        step(1);
        step(3 * TICK_DIV);
        checks++;
        if (react_ms !== TIME_W'(3)) begin
            errors++;
            $display("FAIL mid_reset_pre: react %0d required 3", react_ms);
        end
        rst = 1'b0;
        step(1);
        checks++;
        if ({react_ms, busy, delay_rst_n} !== {TIME_W'(0), 2'b00}) begin
            errors++;
            $display("FAIL mid_reset: react %0d busy %b delay_rst_n %b required 0 0 0", react_ms, busy, delay_rst_n);
        end
        rst  = 1'b1;
        go_n = 1'b1;
        step(2);
    endtask

    task automatic test_start_in_run();
        logic [W-1:0] exp;
        logic [W-1:0] got;
        pulse_start();
        go_n = 1'b0;
        exp_q.push_back({TIME_W'(39 / TICK_DIV), 1'b1, 1'b0, 1'b0});
        step(1);
        step(11);
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(25);
        punch = 1'b1;
        step(3);
        got = {react_ms, result_valid, foul, timeout};
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL start_in_run: got %h required %h", got, exp);
        end
        punch = 1'b0;
        go_n  = 1'b1;
        step(3);
    endtask

    task automatic test_edge_cases();
        logic [W-1:0] exp;
        logic [W-1:0] got;
        // punch registered on a tick edge: react stays at 7, not 8
        play_round(32, 1'b1, "punch_on_tick");
        // go and punch edge in the same ARM cycle
        pulse_start();
        punch = 1'b1;
        step(2);
        go_n = 1'b0;
        exp_q.push_back({TIME_W'(0), 1'b1, 1'b0, 1'b0});
        step(1);
        got = {react_ms, result_valid, foul, timeout};
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp || busy !== 1'b0) begin
            errors++;
            $display("FAIL go_with_punch: got %h busy %b required %h busy 0", got, busy, exp);
        end
        punch = 1'b0;
        go_n  = 1'b1;
        step(3);
    endtask

    task automatic test_random_rounds();
        for (int i = 0; i < 4; i++) begin
            play_round($urandom_range(3, TICK_DIV * MAX_TIME), 1'b1, "random_round");
        end
    endtask

`ifdef BEST_TIME_EN
    task automatic test_best_time();
        logic [TIME_W-1:0] exp_best[3];
        int e_list[3];
        exp_best = '{TIME_W'(7), TIME_W'(7), TIME_W'(5)};
        e_list   = '{30, 50, 22};
        rst = 1'b0;
        step(2);
        rst = 1'b1;
        step(1);
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin
                pulse_start();
                step(1);
                punch = 1'b1;
                step(3);
                punch = 1'b0;
                step(3);
                checks++;
                if (foul !== 1'b1 || best_ms !== TIME_W'(7)) begin
                    errors++;
                    $display("FAIL best_after_foul: foul %b best %0d required 1 7", foul, best_ms);
                end
            end
            play_round(e_list[i], 1'b1, "best_round");
            checks++;
            if (best_ms !== exp_best[i]) begin
                errors++;
                $display("FAIL best_ms_round%0d: got %0d required %0d", i, best_ms, exp_best[i]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_normal();
        test_foul();
        test_timeout();
        test_mid_reset();
        test_start_in_run();
        test_edge_cases();
        test_random_rounds();
`ifdef BEST_TIME_EN
        test_best_time();
`endif
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/reaction_timer.md
Name: reaction_timer

Overview:
Round controller for the boxing reaction game; consumes the active-low "go" level from the delay counter and measures how long the player takes to punch. It holds the delay counter in reset between rounds and releases it to arm a round. The block times the punch in millisecond ticks and flags fouls (early punches) and timeouts. Results go to the score/display logic.

Parameters:
TICK_DIV, 50000, clk cycles per react_ms increment (1 ms at 50 MHz); must be >= 2
TIME_W, 16, width of react_ms
MAX_TIME, 9999, saturation value of react_ms; reaching it ends the round as a timeout; must fit in TIME_W

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-low
start  input  1  one-cycle pulse, active-high; arms a round
go_n  input  1  from delay counter output; low = go
punch  input  1  raw asynchronous punch sensor, active-high
delay_rst_n  output  1  drives delay counter rst; low holds it in reset
busy  output  1  high in ARM and RUN
react_ms  output  TIME_W  measured reaction time in ticks
result_valid  output  1  high in DONE when a legal punch was timed
foul  output  1  high in DONE when the punch came before go
timeout  output  1  high in DONE when MAX_TIME was reached

Behaviour:
- Reset (rst=0 at posedge): state IDLE; delay_rst_n=0; busy=0; react_ms=0; result_valid=0; foul=0; timeout=0; prescaler=0; sync flops=0. Reset in any state, including mid-RUN, takes effect at that edge.
- Punch input path: 2-flop synchronizer (s1, s2), plus s2_d; punch_edge = s2 & ~s2_d. If punch rises before edge k, the state update occurs at edge k+2.
- States: IDLE, ARM, RUN, DONE. All outputs are registered.
- IDLE: delay_rst_n=0. On start=1: go to ARM; clear react_ms and all flags; set delay_rst_n=1 and busy=1.
- ARM: wait for go_n.
  - go_n=0: go to RUN and clear the prescaler. If punch_edge occurs in the same cycle, go directly to DONE with react_ms=0 and result_valid=1 (not a foul).
  - go_n=1 and punch_edge: go to DONE with foul=1 and react_ms=0.
- RUN:
  - The prescaler counts 0..TICK_DIV-1. On the wrap edge, react_ms increments.
  - When the increment would make react_ms == MAX_TIME: write MAX_TIME, set timeout=1, go to DONE.
  - On punch_edge: go to DONE with result_valid=1; react_ms is frozen.
  - punch_edge and a tick in the same cycle: the punch wins and no increment occurs.
  - go_n returning high in RUN is ignored.
- DONE: delay_rst_n=0; busy=0; results held stable. start goes to ARM (same clearing as from IDLE).
- start is ignored in ARM and RUN. punch_edge is ignored in IDLE and DONE.
- Flags are mutually exclusive; at most one is set per round.
- No wrap-around: react_ms saturates and never exceeds MAX_TIME.

Optional Feature:
BEST_TIME_EN:
- With the macro: adds output best_ms [TIME_W-1:0], reset value all ones.
- On entry to DONE with result_valid=1 and react_ms < best_ms, best_ms takes react_ms at that edge.
- Foul and timeout rounds never update best_ms.
- best_ms persists across rounds; only rst clears it.
- Without the macro: the port and register are absent; all other behaviour is identical.

Test Plan:
(Test parameters: TICK_DIV=4, MAX_TIME=20.)
1. Reset: rst=0 for 3 cycles with random inputs -> every output at its reset value, state IDLE, delay_rst_n=0.
2. Normal round: start pulse, go_n falls 5 cycles later, punch timed so detection lands 30 edges after RUN entry -> react_ms=7, result_valid=1, foul=0, timeout=0, delay_rst_n back to 0, busy=0.
3. Foul: start, punch while go_n=1 -> foul=1, react_ms=0, result_valid=0. A second start re-arms the round and clears foul.
4. Timeout: start, go_n low, no punch -> react_ms steps 1..20, timeout=1 at the edge it reaches 20, DONE, no further increments.
5. Mid-round reset and edge cases:
   - rst=0 during RUN with react_ms=3 -> next edge react_ms=0, busy=0, delay_rst_n=0.
   - start during RUN is ignored.
   - punch_edge coincident with a tick -> react_ms not incremented.
6. BEST_TIME_EN: three valid rounds of 7, 12, 5 with a foul in between -> best_ms=7, 7, 5; the foul round leaves it unchanged.
